dmem_responder: RTL and testbench

- Multi-cycle backing-memory responder on the data-memory side of the dcache refill/writeback interface.
- Accepts the dcache's rden/wren request with read and write addresses and 64-bit write data.
- Performs the access after a configurable latency, then returns read data with a one-cycle mem_ready pulse.
- Replaces the zero-latency data memory so cache miss handling is exercised under realistic timing.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_responder_array.sv | 50 +++++
 rtl/dmem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and helpers for the dmem_responder slice.
// State encodings, the byte-to-word offset and an index-width helper.
`timescale 1ns/1ps
package dmem_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Byte address bits below this position select a byte within a 64-bit word.
    localparam int WORD_LSB = 3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_RESP = S_RESP
    } state_e;

    // Number of bits needed to index 'value' entries (value >= 1).
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: dcache <-> backing data memory request/response bundle.
// Optional out-of-range flag present only when DMEM_RESPONDER_OOR_EN is defined.
`timescale 1ns/1ps
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              rden;
    logic              wren;
    logic [ADDR_W-1:0] rdaddress;
    logic [ADDR_W-1:0] wraddress;
    logic [63:0]       write_data;
    logic [63:0]       read_data;
    logic              mem_ready;
    logic              busy;
`ifdef DMEM_RESPONDER_OOR_EN
    logic              oor_err;
`endif

    // Requester (dcache) side.
    modport master (
        output rden, wren, rdaddress, wraddress, write_data,
        input  read_data, mem_ready, busy
`ifdef DMEM_RESPONDER_OOR_EN
        , input oor_err
`endif
    );

    // Responder (memory) side.
    modport slave (
        input  rden, wren, rdaddress, wraddress, write_data,
        output read_data, mem_ready, busy
`ifdef DMEM_RESPONDER_OOR_EN
        , output oor_err
`endif
    );

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: 64-bit word storage, one synchronous write and one synchronous
// read port. A read that hits the word written on the same edge returns the
// new data. The read register resets to zero and holds between reads; the
// storage itself is never reset.
`timescale 1ns/1ps
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [63:0]      i_wr_data,
    input  logic             i_re,
    input  logic             i_rd_clr,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [63:0]      o_rd_data
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rd_data;

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Read register: zero-load, same-edge forwarding, or array read; holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= 64'h0;
        end else if (i_re) begin
            if (i_rd_clr) begin
                r_rd_data <= 64'h0;
            end else if (i_we && (i_rd_idx == i_wr_idx)) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[i_rd_idx];
            end
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle backing memory for the dcache refill/writeback
// path. Latches one request in IDLE, waits LATENCY cycles, performs write then
// read (with forwarding), and pulses mem_ready for one cycle.
// Optional build macro: DMEM_RESPONDER_OOR_EN adds out-of-range detection
// (oor_err, dropped writes, zero reads); without it addresses wrap modulo DEPTH.
`timescale 1ns/1ps
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int         IDX_W  = clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_accept;
    logic             w_access;

    logic             r_rden;
    logic             r_wren;
    logic [IDX_W-1:0] r_rd_idx;
    logic [IDX_W-1:0] r_wr_idx;
    logic [63:0]      r_wdata;
    logic             r_mem_ready;
    logic             r_busy;

    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [ADDR_W-1:0] w_rd_upper;
    logic [ADDR_W-1:0] w_wr_upper;
    logic              w_we;
    logic              w_re;
    logic              w_rd_clr;
    logic [63:0]       w_rd_data;

    assign w_rd_idx   = bus.rdaddress[IDX_W+WORD_LSB-1:WORD_LSB];
    assign w_wr_idx   = bus.wraddress[IDX_W+WORD_LSB-1:WORD_LSB];
    assign w_rd_upper = bus.rdaddress >> (IDX_W + WORD_LSB);
    assign w_wr_upper = bus.wraddress >> (IDX_W + WORD_LSB);

`ifdef DMEM_RESPONDER_OOR_EN
    logic r_rd_oor;
    logic r_wr_oor;
    logic r_oor_err;
    logic w_oor_hit;
    logic w_unused_addr;

    // An access is out of range when it is requested and its upper bits are set.
    assign w_oor_hit = (r_rden & r_rd_oor) | (r_wren & r_wr_oor);
    assign w_we      = w_access & r_wren & ~r_wr_oor;
    assign w_re      = w_access & r_rden;
    assign w_rd_clr  = r_rd_oor;

    // Byte-offset bits are not part of the word address.
    assign w_unused_addr = ^{bus.rdaddress[WORD_LSB-1:0], bus.wraddress[WORD_LSB-1:0]};

    // Range flags captured alongside the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_oor <= 1'b0;
            r_wr_oor <= 1'b0;
        end else if (w_accept) begin
            r_rd_oor <= (w_rd_upper != {ADDR_W{1'b0}});
            r_wr_oor <= (w_wr_upper != {ADDR_W{1'b0}});
        end else begin
            r_rd_oor <= r_rd_oor;
            r_wr_oor <= r_wr_oor;
        end
    end

    // Error flag shown only in the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oor_err <= 1'b0;
        end else if (w_state_nxt == ST_RESP) begin
            r_oor_err <= w_oor_hit;
        end else begin
            r_oor_err <= 1'b0;
        end
    end

    assign bus.oor_err = r_oor_err;
`else
    logic w_unused_addr;

    // Upper address bits wrap silently; byte-offset bits are ignored.
    assign w_we     = w_access & r_wren;
    assign w_re     = w_access & r_rden;
    assign w_rd_clr = 1'b0;

    assign w_unused_addr = ^{bus.rdaddress[WORD_LSB-1:0], bus.wraddress[WORD_LSB-1:0],
                             w_rd_upper, w_wr_upper};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Next-state, counter and access strobes; inputs only matter in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rden | bus.wren) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Request latch: capture both commands, indices and write data on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rden   <= 1'b0;
            r_wren   <= 1'b0;
            r_rd_idx <= {IDX_W{1'b0}};
            r_wr_idx <= {IDX_W{1'b0}};
            r_wdata  <= 64'h0;
        end else if (w_accept) begin
            r_rden   <= bus.rden;
            r_wren   <= bus.wren;
            r_rd_idx <= w_rd_idx;
            r_wr_idx <= w_wr_idx;
            r_wdata  <= bus.write_data;
        end else begin
            r_rden   <= r_rden;
            r_wren   <= r_wren;
            r_rd_idx <= r_rd_idx;
            r_wr_idx <= r_wr_idx;
            r_wdata  <= r_wdata;
        end
    end

    // Registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_ready <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (r_wdata),
        .i_re      (w_re),
        .i_rd_clr  (w_rd_clr),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign bus.read_data = w_rd_data;
    assign bus.mem_ready = r_mem_ready;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven transactions on a LATENCY=4 instance with a
// scoreboard queue, plus hand sequences for reset abort and LATENCY=1 streaming.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32)) if4 ();
    dmem_responder_if #(.ADDR_W(32)) if1 ();

    dmem_responder #(.DEPTH(1024), .LATENCY(4), .ADDR_W(32)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1), .ADDR_W(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] rda;
        logic [31:0] wra;
        logic [63:0] wd;
        logic [63:0] exp_data;
        logic        exp_oor;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] rda,
                                input logic [31:0] wra, input logic [63:0] wd,
                                input logic [63:0] exp_data, input logic exp_oor);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rda = rda; v.wra = wra; v.wd = wd;
        v.exp_data = exp_data; v.exp_oor = exp_oor;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   n;
        bit   seen;
        vec_t e;
        @(negedge clk);
        if4.rden = v.rd; if4.wren = v.wr;
        if4.rdaddress = v.rda; if4.wraddress = v.wra; if4.write_data = v.wd;
        sb.push_back(v);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check({tag, "_busy_wait"}, 64'(if4.busy), 64'd1);
            if (if4.mem_ready) seen = 1'b1;
        end
        if4.rden = 1'b0; if4.wren = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: actual no mem_ready required mem_ready within 40 cycles", tag);
        end else begin
            // Accept edge plus LATENCY edges.
            check({tag, "_latency"}, 64'(n), 64'd5);
            check({tag, "_data"}, if4.read_data, e.exp_data);
`ifdef DMEM_RESPONDER_OOR_EN
            check({tag, "_oor"}, 64'(if4.oor_err), 64'(e.exp_oor));
`endif
            @(posedge clk);
            @(negedge clk);
            check({tag, "_pulse_end"}, 64'(if4.mem_ready), 64'd0);
            check({tag, "_idle"}, 64'(if4.busy), 64'd0);
            check({tag, "_hold"}, if4.read_data, e.exp_data);
        end
    endtask

    initial begin
        int   phase;
        int   pulses;
        int   n;
        bit   seen;

        rst = 1'b0;
        if4.rden = 1'b0; if4.wren = 1'b0; if4.rdaddress = 32'h0; if4.wraddress = 32'h0;
        if4.write_data = 64'h0;
        if1.rden = 1'b0; if1.wren = 1'b0; if1.rdaddress = 32'h0; if1.wraddress = 32'h0;
        if1.write_data = 64'h0;

        // Vector table: {rd, wr, rdaddr, wraddr, wdata, expected read_data, expected oor}.
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,    32'h40,   64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h40,   32'h0,    64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h80,   32'h80,   64'h1111, 64'h1111, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,    32'h47,   64'h5555_AAAA_0000_FFFF, 64'h1111, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h40,   32'h0,    64'h0, 64'h5555_AAAA_0000_FFFF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h45,   32'h0,    64'h0, 64'h5555_AAAA_0000_FFFF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,    32'h100,  64'h0123_4567_89AB_CDEF,
                          64'h5555_AAAA_0000_FFFF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h80,   32'hC0,   64'h77, 64'h1111, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'hC0,   32'h0,    64'h0, 64'h77, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,    32'h2000, 64'hAA, 64'h77, 1'b1));
`ifdef DMEM_RESPONDER_OOR_EN
        vecs.push_back(mk(1'b1, 1'b0, 32'h2000, 32'h0,    64'h0, 64'h0, 1'b1));
`else
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,    32'h0,    64'h0, 64'hAA, 1'b0));
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rdata", if4.read_data, 64'h0);
        check("rst_ready", 64'(if4.mem_ready), 64'd0);
        check("rst_busy", 64'(if4.busy), 64'd0);
        check("rst_busy_l1", 64'(if1.busy), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Abort a write to 0x100 in the middle of WAIT.
        @(negedge clk);
        if4.wren = 1'b1; if4.wraddress = 32'h100; if4.write_data = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 64'(if4.busy), 64'd1);
        rst = 1'b0;
        #1;
        check("abort_async_busy", 64'(if4.busy), 64'd0);
        check("abort_async_rdata", if4.read_data, 64'h0);
        repeat (6) @(negedge clk);
        if4.wren = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rdata", if4.read_data, 64'h0);
        check("abort_ready", 64'(if4.mem_ready), 64'd0);
        check("abort_busy", 64'(if4.busy), 64'd0);
        run_txn(mk(1'b1, 1'b0, 32'h100, 32'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0), "abort_rd");

        // LATENCY=1: preload a word, then hold a read continuously.
        @(negedge clk);
        if1.wren = 1'b1; if1.wraddress = 32'h8; if1.write_data = 64'h99;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (if1.mem_ready) seen = 1'b1;
        end
        if1.wren = 1'b0;
        check("l1_wr_latency", 64'(n), 64'd2);
        @(negedge clk);
        if1.rden = 1'b1; if1.rdaddress = 32'h8;
        phase = 0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("l1_ready_c%0d", c), 64'(if1.mem_ready), 64'(phase == 1));
            check($sformatf("l1_busy_c%0d", c), 64'(if1.busy), 64'(phase != 2));
            if (phase == 1) begin
                check($sformatf("l1_data_c%0d", c), if1.read_data, 64'h99);
            end
            if (if1.mem_ready) pulses++;
            phase = (phase + 1) % 3;
        end
        if1.rden = 1'b0;
        check("l1_pulses", 64'(pulses), 64'd4);
        repeat (3) @(negedge clk);
        check("l1_final_idle", 64'(if1.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
